ebpf_host_ctl: RTL and testbench

Host-side driver for the eBPF CPU's CSR/MMIO register interface, and the opposite end of that interface from the CPU. It accepts a job (five 64-bit arguments), loads them into CPU input registers r1-r5, and pulses the CPU's rst_n control bit to start execution. It then waits for halt or error in the CPU status register, with a timeout. When the run ends it captures r0, r6-r10 and ticks, and returns them as one result beat over a valid/ready handshake.

---
 rtl/ebpf_pkg.sv | 30 +++
 rtl/ebpf_run_timer.sv | 56 +++++
 rtl/ebpf_host_ctl.sv | 177 +++++++++++++++++
 tb/tb_ebpf_host_ctl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ebpf_pkg.sv
// Shared definitions for the eBPF host controller: CSR bit positions,
// result codes, register geometry and the controller state encoding.
package ebpf_pkg;

   // r_ctl / r_status bit positions
   localparam int CTL_RSTN = 0;
   localparam int ST_RSTN  = 0;
   localparam int ST_HALT  = 1;
   localparam int ST_ERR   = 2;
   localparam int ST_DBG   = 7;

   // Result codes returned with each result beat
   localparam logic [1:0] RES_OK      = 2'b00;
   localparam logic [1:0] RES_ERR     = 2'b01;
   localparam logic [1:0] RES_TIMEOUT = 2'b10;

   // CPU register geometry: r1-r5 in, r6-r10 out, 64-bit registers
   localparam int NUM_ARGS = 5;
   localparam int NUM_OUTS = 5;
   localparam int REG_W    = 64;

   // Controller states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_RUN  = 2'd2,
      S_RESP = 2'd3
   } state_e;

endpackage

// File: rtl/ebpf_run_timer.sv
// Cycle counters for the host controller: a loadable down-counter that
// times the CPU reset pulse, and an up-counter that measures the run
// and flags the last permitted run cycle.
module ebpf_run_timer #(
   parameter int CNT_W          = 32,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold_load_i,
   input  logic [CNT_W-1:0] hold_val_i,
   input  logic             hold_dec_i,
   input  logic             run_clr_i,
   input  logic             run_inc_i,
   output logic             hold_zero_o,
   output logic [CNT_W-1:0] run_cnt_o,
   output logic             run_last_o
);

   localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] run_q, run_d;

   // Next-state for both counters; load/clear take priority over counting
   always_comb begin
      hold_d = hold_q;
      run_d  = run_q;
      if (hold_load_i) begin
         hold_d = hold_val_i;
      end else if (hold_dec_i && (hold_q != '0)) begin
         hold_d = hold_q - 1'b1;
      end
      if (run_clr_i) begin
         run_d = '0;
      end else if (run_inc_i) begin
         run_d = run_q + 1'b1;
      end
   end

   // Counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
         run_q  <= '0;
      end else begin
         hold_q <= hold_d;
         run_q  <= run_d;
      end
   end

   assign hold_zero_o = (hold_q == '0);
   assign run_cnt_o   = run_q;
   assign run_last_o  = (run_q == RUN_LAST);

endmodule

// File: rtl/ebpf_host_ctl.sv
// Host-side driver for the eBPF CPU CSR interface. Loads a job's five
// arguments into r1-r5, pulses the CPU reset for RST_HOLD cycles, runs
// until halt, error or timeout, then returns r0, r6-r10, ticks and the
// run length as a single result beat.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. job_ready is high only in IDLE; res_valid is high only
// in RESP and res_* hold steady until res_ready is seen.
module ebpf_host_ctl
   import ebpf_pkg::*;
#(
   parameter int RST_HOLD       = 4,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int CNT_W          = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      job_valid,
   output logic                      job_ready,
   input  logic [NUM_ARGS*REG_W-1:0] job_args,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [1:0]                res_code,
   output logic [REG_W-1:0]          res_r0,
   output logic [NUM_OUTS*REG_W-1:0] res_outs,
   output logic [REG_W-1:0]          res_ticks,
   output logic [CNT_W-1:0]          res_cycles,
   output logic [NUM_ARGS*REG_W-1:0] cpu_args,
   output logic [7:0]                cpu_ctl,
   input  logic [7:0]                cpu_status,
   input  logic [REG_W-1:0]          cpu_r0,
   input  logic [NUM_OUTS*REG_W-1:0] cpu_outs,
   input  logic [REG_W-1:0]          cpu_ticks
);

   localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(RST_HOLD - 1);

   state_e                      state_q, state_d;
   logic [NUM_ARGS*REG_W-1:0]   args_q, args_d;
   logic [1:0]                  res_code_q, res_code_d;
   logic [REG_W-1:0]            res_r0_q, res_r0_d;
   logic [NUM_OUTS*REG_W-1:0]   res_outs_q, res_outs_d;
   logic [REG_W-1:0]            res_ticks_q, res_ticks_d;
   logic [CNT_W-1:0]            res_cycles_q, res_cycles_d;

   logic                        hold_load, hold_dec, run_clr, run_inc;
   logic                        hold_zero, run_last;
   logic [CNT_W-1:0]            run_cnt;
   logic                        term;
   logic [1:0]                  term_code;

   // Debug bit and reserved status bits carry no meaning for this block
   logic unused_status;
   assign unused_status = ^{cpu_status[ST_DBG], cpu_status[6:3]};

   ebpf_run_timer #(
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .hold_load_i (hold_load),
      .hold_val_i  (HOLD_INIT),
      .hold_dec_i  (hold_dec),
      .run_clr_i   (run_clr),
      .run_inc_i   (run_inc),
      .hold_zero_o (hold_zero),
      .run_cnt_o   (run_cnt),
      .run_last_o  (run_last)
   );

   // Run termination: status only counts once the CPU echoes rst_n, so a
   // halt left over from the previous run is ignored; error beats halt,
   // and both beat timeout
   always_comb begin
      term      = 1'b0;
      term_code = RES_OK;
      if (cpu_status[ST_RSTN] && cpu_status[ST_ERR]) begin
         term      = 1'b1;
         term_code = RES_ERR;
      end else if (cpu_status[ST_RSTN] && cpu_status[ST_HALT]) begin
         term      = 1'b1;
         term_code = RES_OK;
      end else if (run_last) begin
         term      = 1'b1;
         term_code = RES_TIMEOUT;
      end
   end

   // Next-state and datapath control for the job/run/response sequence
   always_comb begin
      state_d      = state_q;
      args_d       = args_q;
      res_code_d   = res_code_q;
      res_r0_d     = res_r0_q;
      res_outs_d   = res_outs_q;
      res_ticks_d  = res_ticks_q;
      res_cycles_d = res_cycles_q;
      hold_load    = 1'b0;
      hold_dec     = 1'b0;
      run_clr      = 1'b0;
      run_inc      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (job_valid) begin
               args_d    = job_args;
               hold_load = 1'b1;
               state_d   = S_HOLD;
            end
         end
         S_HOLD: begin
            if (hold_zero) begin
               run_clr = 1'b1;
               state_d = S_RUN;
            end else begin
               hold_dec = 1'b1;
            end
         end
         S_RUN: begin
            run_inc = 1'b1;
            if (term) begin
               res_code_d   = term_code;
               res_r0_d     = cpu_r0;
               res_outs_d   = cpu_outs;
               res_ticks_d  = cpu_ticks;
               res_cycles_d = run_cnt + 1'b1;
               state_d      = S_RESP;
            end
         end
         S_RESP: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers; reset discards any pending result
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         args_q       <= '0;
         res_code_q   <= RES_OK;
         res_r0_q     <= '0;
         res_outs_q   <= '0;
         res_ticks_q  <= '0;
         res_cycles_q <= '0;
      end else begin
         state_q      <= state_d;
         args_q       <= args_d;
         res_code_q   <= res_code_d;
         res_r0_q     <= res_r0_d;
         res_outs_q   <= res_outs_d;
         res_ticks_q  <= res_ticks_d;
         res_cycles_q <= res_cycles_d;
      end
   end

   // CPU is held in reset everywhere except RUN
   always_comb begin
      cpu_ctl           = '0;
      cpu_ctl[CTL_RSTN] = (state_q == S_RUN);
   end

   assign job_ready  = (state_q == S_IDLE);
   assign res_valid  = (state_q == S_RESP);
   assign cpu_args   = args_q;
   assign res_code   = res_code_q;
   assign res_r0     = res_r0_q;
   assign res_outs   = res_outs_q;
   assign res_ticks  = res_ticks_q;
   assign res_cycles = res_cycles_q;

endmodule

// File: tb/tb_ebpf_host_ctl.sv
// Bench for ebpf_host_ctl: directed scenarios followed by random jobs.
// The CPU is emulated per run cycle from three parameters (cycle at which
// rst_n is echoed, cycle at which halt / error rise); the expected result
// is derived arithmetically from those parameters.
module tb_ebpf_host_ctl;

   localparam int RST_HOLD = 4;
   localparam int TO       = 20;
   localparam int CNT_W    = 32;
   localparam int NEVER    = 1000;

   logic           clk = 1'b0;
   logic           rst;
   logic           job_valid;
   logic           job_ready;
   logic [319:0]   job_args;
   logic           res_valid;
   logic           res_ready;
   logic [1:0]     res_code;
   logic [63:0]    res_r0;
   logic [319:0]   res_outs;
   logic [63:0]    res_ticks;
   logic [CNT_W-1:0] res_cycles;
   logic [319:0]   cpu_args;
   logic [7:0]     cpu_ctl;
   logic [7:0]     cpu_status;
   logic [63:0]    cpu_r0;
   logic [319:0]   cpu_outs;
   logic [63:0]    cpu_ticks;

   int n_cmp  = 0;
   int n_fail = 0;

   ebpf_host_ctl #(
      .RST_HOLD       (RST_HOLD),
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .job_valid  (job_valid),
      .job_ready  (job_ready),
      .job_args   (job_args),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_code   (res_code),
      .res_r0     (res_r0),
      .res_outs   (res_outs),
      .res_ticks  (res_ticks),
      .res_cycles (res_cycles),
      .cpu_args   (cpu_args),
      .cpu_ctl    (cpu_ctl),
      .cpu_status (cpu_status),
      .cpu_r0     (cpu_r0),
      .cpu_outs   (cpu_outs),
      .cpu_ticks  (cpu_ticks)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [319:0] pack5(input logic [63:0] a, b, c, d, e);
      return {e, d, c, b, a};
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Expected outcome from the emulated CPU's parameters: the run ends on
   // the first cycle where rst_n is echoed and halt or error is up, unless
   // that lies past the timeout cycle
   task automatic model(input int echo, input int halt, input int err,
                        output logic [1:0] code, output int cycles);
      int h, e, f, k;
      h = (halt == 0) ? NEVER : halt;
      e = (err == 0) ? NEVER : err;
      f = (h < e) ? h : e;
      k = (echo > f) ? echo : f;
      if (k > TO) begin
         code   = 2'b10;
         cycles = TO;
      end else begin
         code   = (e <= k) ? 2'b01 : 2'b00;
         cycles = k;
      end
   endtask

   // One complete job: accept, reset pulse, run, response with optional
   // backpressure (and optionally a next job presented during RESP)
   task automatic do_job(input logic [319:0] args, input int echo, input int halt,
                         input int err, input logic [63:0] r0, input logic [319:0] outs,
                         input logic [63:0] ticks, input int delay, input bit bp,
                         input logic [319:0] nargs);
      int wait_n, hold_n, n, exp_cycles;
      logic [1:0] exp_code;
      model(echo, halt, err, exp_code, exp_cycles);
      job_valid = 1'b1;
      job_args  = args;
      wait_n = 0;
      while (!job_ready && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      chk("job_ready_wait", job_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      job_valid = 1'b0;
      job_args  = ~args;
      chk("cpu_args", cpu_args, args);
      cpu_r0    = r0;
      cpu_outs  = outs;
      cpu_ticks = ticks;
      hold_n = 0;
      while (!cpu_ctl[0] && hold_n < 50) begin
         chk("job_ready_hold", job_ready, 1'b0);
         hold_n++;
         @(negedge clk);
      end
      chk("hold_cycles", hold_n, RST_HOLD);
      n = 1;
      while (cpu_ctl[0] && n <= TO + 5) begin
         cpu_status[0] = (n >= echo);
         cpu_status[1] = (halt != 0) && (n >= halt);
         cpu_status[2] = (err != 0) && (n >= err);
         cpu_status[7] = $urandom_range(0, 1);
         @(negedge clk);
         n++;
      end
      cpu_status = '0;
      cpu_r0     = ~r0;
      cpu_outs   = ~outs;
      cpu_ticks  = ~ticks;
      chk("run_ended", n <= TO + 5, 1'b1);
      if (bp) begin
         job_valid = 1'b1;
         job_args  = nargs;
      end
      for (int i = 0; i <= delay; i++) begin
         chk("res_valid", res_valid, 1'b1);
         chk("ctl_resp", cpu_ctl, 8'h00);
         chk("job_ready_resp", job_ready, 1'b0);
         chk("res_code", res_code, exp_code);
         chk("res_r0", res_r0, r0);
         chk("res_outs", res_outs, outs);
         chk("res_ticks", res_ticks, ticks);
         chk("res_cycles", res_cycles, exp_cycles);
         if (i == delay) res_ready = 1'b1;
         @(negedge clk);
      end
      res_ready = 1'b0;
      chk("res_valid_after", res_valid, 1'b0);
      chk("job_ready_after", job_ready, 1'b1);
      chk("args_kept", cpu_args, args);
   endtask

   // Stimulus
   initial begin
      logic [319:0] a, o;
      int echo, halt, err;
      rst        = 1'b1;
      job_valid  = 1'b0;
      job_args   = '0;
      res_ready  = 1'b0;
      cpu_status = '0;
      cpu_r0     = '0;
      cpu_outs   = '0;
      cpu_ticks  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset values
      chk("rst_job_ready", job_ready, 1'b1);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_code", res_code, 2'b00);
      chk("rst_res_r0", res_r0, 64'h0);
      chk("rst_res_outs", res_outs, 320'h0);
      chk("rst_res_ticks", res_ticks, 64'h0);
      chk("rst_res_cycles", res_cycles, 32'h0);
      chk("rst_cpu_args", cpu_args, 320'h0);
      chk("rst_cpu_ctl", cpu_ctl, 8'h00);

      // Normal halt
      do_job(pack5(1, 2, 3, 4, 5), 1, 11, 0, 64'hDEAD, pack5(64'h66, 0, 0, 0, 0),
             64'd10, 0, 1'b0, '0);
      // Error together with halt in the 3rd run cycle
      do_job(rnd64(), 1, 3, 3, rnd64(), {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()},
             rnd64(), 1, 1'b0, '0);
      // Timeout
      do_job(rnd64(), 1, 0, 0, rnd64(), {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()},
             rnd64(), 0, 1'b0, '0);
      // Stale halt until rst_n is echoed in cycle 4
      do_job(rnd64(), 4, 1, 0, rnd64(), {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()},
             rnd64(), 0, 1'b0, '0);
      // Backpressure with the next job waiting
      a = pack5(9, 10, 11, 12, 13);
      do_job(rnd64(), 2, 6, 0, rnd64(), {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()},
             rnd64(), 7, 1'b1, a);
      do_job(a, 1, 5, 0, rnd64(), {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()},
             rnd64(), 0, 1'b0, '0);

      // Reset in the 5th run cycle
      job_valid = 1'b1;
      job_args  = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
      @(posedge clk);
      @(negedge clk);
      job_valid = 1'b0;
      repeat (RST_HOLD) @(negedge clk);
      chk("run_entered", cpu_ctl, 8'h01);
      cpu_status = 8'h01;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cpu_status = 8'h03;
      chk("mid_rst_job_ready", job_ready, 1'b1);
      chk("mid_rst_cpu_ctl", cpu_ctl, 8'h00);
      chk("mid_rst_cpu_args", cpu_args, 320'h0);
      chk("mid_rst_res_valid", res_valid, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_no_result", res_valid, 1'b0);
      end
      cpu_status = '0;

      // Random jobs
      for (int j = 0; j < 10; j++) begin
         echo = $urandom_range(1, 5);
         halt = $urandom_range(0, 25);
         err  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 25) : 0;
         a = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
         o = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
         do_job(a, echo, halt, err, rnd64(), o, rnd64(), $urandom_range(0, 3), 1'b0, '0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Global time bound
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "bench time limit");
   end

endmodule
